fp_div_iter: RTL and testbench
==============================

FP_DIV_ITER -- requirements
Module: fp_div_iter

Interface
REQ-001 SHALL have parameter EXP_W, default 8, exponent field width.
REQ-002 SHALL have parameter MAN_W, default 23, stored fraction width; DATA_W = 1+EXP_W+MAN_W; BIAS = 2^(EXP_W-1)-1.
REQ-003 SHALL have port clk  input  1  clock, all state on rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port start  input  1  request; sampled only when busy=0.
REQ-006 SHALL have ports op_a, op_b  input  DATA_W  dividend, divisor; captured on the accepted start edge.
REQ-007 SHALL have port busy  output  1  high from the accept edge until the edge done asserts.
REQ-008 SHALL have port done  output  1  one-cycle pulse; res and flags valid.
REQ-009 SHALL have port res  output  DATA_W  quotient; held until the next done.
REQ-010 SHALL have ports overflow, underflow, invalid, div_by_zero  output  1 each  exception flags; valid with done, held with res.

Function
REQ-011 SHALL implement FSM IDLE -> UNPACK (1 cycle) -> DIVIDE (MAN_W+3 cycles) -> NORM (1) -> ROUND (1) -> IDLE.
REQ-012 SHALL assert done exactly MAN_W+6 rising edges after the accept edge (29 at defaults); latency is fixed for all operands, including special cases.
REQ-013 SHALL ignore start while busy=1; a start on the edge done asserts is ignored; back-to-back issue is the earliest start one cycle after done.
REQ-014 SHALL treat exponent-zero inputs (subnormals) as zero; no subnormal outputs.
REQ-015 SHALL compute sign = sa^sb; exponent e = ea-eb+BIAS in signed EXP_W+2 bits.
REQ-016 SHALL produce MAN_W+3 quotient bits of {1,fa}/{1,fb} by restoring division, one bit per DIVIDE cycle, plus sticky = (final remainder != 0).
REQ-017 SHALL in NORM shift the quotient left 1 and decrement e when its MSB is 0.
REQ-018 SHALL round to nearest, ties to even, on guard bit and sticky (remaining low bits ORed in); mantissa carry-out increments e.
REQ-019 SHALL on final e >= 2^EXP_W-1 output signed infinity and set overflow.
REQ-020 SHALL on final e <= 0 output signed zero and set underflow.
REQ-021 SHALL for a NaN operand, 0/0 or inf/inf output canonical qNaN (sign 0, exponent all ones, fraction MSB only) and set invalid.
REQ-022 SHALL for finite nonzero/0 output signed infinity and set div_by_zero.
REQ-023 SHALL for inf/finite output signed infinity, and for finite/inf or 0/nonzero output signed zero, with no flag set.
REQ-024 SHALL set no flag other than the one the operands cause.

Reset
REQ-025 SHALL on rst force state IDLE, busy=0, done=0, res=0, all flags 0, iteration counter 0.
REQ-026 SHALL abandon an in-flight operation on rst; no done follows for that operation.

Structure
REQ-027 SHALL place BIAS, the canonical-NaN constant and the FSM state encodings in the shared fp definitions include, parametrised by EXP_W/MAN_W.
REQ-028 SHALL instantiate one sub-module fp_div_mant: an iterative restoring mantissa divider (load, en, quotient, sticky); unpack, special-case, normalise and round logic stay in fp_div_iter.

Verification
REQ-029 SHALL cover: defaults, 0x40C00000 / 0x40000000 -> res 0x40400000, no flags, done 29 cycles after start.
REQ-030 SHALL cover: 0x3F800000 / 0x40400000 -> 0x3EAAAAAB (round up); with EXP_W=5, MAN_W=10, 0x3C00 / 0x4200 -> 0x3555, done 16 cycles after start.
REQ-031 SHALL cover: 0x3F800000 / 0x00000000 -> 0x7F800000 with div_by_zero=1; 0/0 -> 0x7FC00000 with invalid=1.
REQ-032 SHALL cover: 0x7F7FFFFF / 0x3F000000 -> 0x7F800000 with overflow=1; 0x00800000 / 0x40000000 -> 0x00000000 with underflow=1.
REQ-033 SHALL cover: start pulsed mid-operation with other operands -> ignored; first result unchanged and a single done.
REQ-034 SHALL cover: rst asserted during DIVIDE -> all outputs 0 immediately and no done; a new start then completes normally.

Source files
------------

// File: rtl/fp_div_iter_pkg.sv
// Shared definitions for the iterative floating-point divider: state encoding,
// exception flag bundle and format constants derived from the field widths.
package fp_div_iter_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_UNPACK = 3'd1,
    S_DIVIDE = 3'd2,
    S_NORM   = 3'd3,
    S_ROUND  = 3'd4
  } state_t;

  typedef struct packed {
    logic overflow;
    logic underflow;
    logic invalid;
    logic div_by_zero;
  } fp_flags_t;

  function automatic int fp_bias(input int exp_w);
    return (1 << (exp_w - 1)) - 1;
  endfunction

  // Canonical quiet NaN: sign 0, exponent all ones, only the fraction MSB set.
  function automatic logic [63:0] fp_qnan(input int exp_w, input int man_w);
    logic [63:0] v;
    v = ((64'd1 << exp_w) - 64'd1) << man_w;
    v = v | (64'd1 << (man_w - 1));
    return v;
  endfunction

endpackage

// File: rtl/fp_div_iter_mant.sv
// Iterative restoring divider for normalised mantissas: one quotient bit per
// enabled cycle, with a sticky bit reporting a nonzero final remainder.
module fp_div_mant #(
  parameter int MAN_W = 23
) (
  input  logic             clk,
  input  logic             load,
  input  logic             en,
  input  logic [MAN_W:0]   dividend,
  input  logic [MAN_W:0]   divisor,
  output logic [MAN_W+2:0] quotient,
  output logic             sticky
);

  logic [MAN_W+1:0] rem_p0;
  logic [MAN_W:0]   div_p0;
  logic [MAN_W+1:0] diff;
  logic             ge;

  assign ge     = (rem_p0 >= {1'b0, div_p0});
  assign diff   = rem_p0 - {1'b0, div_p0};
  assign sticky = (rem_p0 != '0);

  // Partial remainder never reaches 2*divisor, so MAN_W+2 bits hold it after the shift.
  always_ff @(posedge clk) begin
    if (load) begin
      rem_p0   <= {1'b0, dividend};
      div_p0   <= divisor;
      quotient <= '0;
    end else if (en) begin
      rem_p0   <= ge ? {diff[MAN_W:0], 1'b0} : {rem_p0[MAN_W:0], 1'b0};
      quotient <= {quotient[MAN_W+1:0], ge};
    end
  end

endmodule

// File: rtl/fp_div_iter.sv
// Multi-cycle IEEE-style divider: unpack and special-case detection, iterative
// mantissa division, single-step normalisation, round-to-nearest-even and packing.
module fp_div_iter
  import fp_div_iter_pkg::*;
#(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic [EXP_W+MAN_W:0]       op_a,
  input  logic [EXP_W+MAN_W:0]       op_b,
  output logic                       busy,
  output logic                       done,
  output logic [EXP_W+MAN_W:0]       res,
  output logic                       overflow,
  output logic                       underflow,
  output logic                       invalid,
  output logic                       div_by_zero
);

  localparam int DATA_W = 1 + EXP_W + MAN_W;
  localparam int EW     = EXP_W + 2;
  localparam int QW     = MAN_W + 3;
  localparam int CNT_W  = $clog2(QW + 1);
  localparam logic signed [EW-1:0] BIAS = EW'(fp_bias(EXP_W));
  localparam logic signed [EW-1:0] EMAX = EW'((1 << EXP_W) - 1);
  localparam logic [DATA_W-1:0]    QNAN = DATA_W'(fp_qnan(EXP_W, MAN_W));

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q;
  logic               load, en;

  logic [DATA_W-1:0]  a_p0, b_p0;
  logic               sgn_p1, spec_p1;
  logic [DATA_W-1:0]  spec_res_p1;
  fp_flags_t          spec_flg_p1;
  logic signed [EW-1:0] e_p1, e_p2;
  logic [QW-1:0]      qn_p2;
  logic               stk_p2;

  logic [QW-1:0]      quo;
  logic               stk;

  logic               sa, sb, sgn;
  logic [EXP_W-1:0]   ea, eb;
  logic [MAN_W-1:0]   fa, fb;
  logic               a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
  logic               spec;
  logic [DATA_W-1:0]  spec_res;
  fp_flags_t          spec_flg;
  logic signed [EW-1:0] e_unp;

  logic [MAN_W+1:0]   rnd;
  logic signed [EW-1:0] e_fin;
  logic [DATA_W+1:0]  packed_res;

  function automatic logic [MAN_W+1:0] round_ne(input logic [MAN_W:0] m,
                                                input logic g, input logic s);
    logic up;
    up = g & (s | m[0]);
    return {1'b0, m} + (MAN_W+2)'(up);
  endfunction

  // Returns {overflow, underflow, word}; exponent out of range saturates to inf or zero.
  function automatic logic [DATA_W+1:0] pack_sat(input logic s, input logic signed [EW-1:0] e,
                                                 input logic [MAN_W-1:0] f);
    if (e >= EMAX)
      return {2'b10, s, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    else if (e <= 0)
      return {2'b01, s, {(DATA_W-1){1'b0}}};
    else
      return {2'b00, s, e[EXP_W-1:0], f};
  endfunction

  fp_div_mant #(.MAN_W(MAN_W)) u_mant (
    .clk      (clk),
    .load     (load),
    .en       (en),
    .dividend ({1'b1, fa}),
    .divisor  ({1'b1, fb}),
    .quotient (quo),
    .sticky   (stk)
  );

  assign busy = (state_q != S_IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= (state_q == S_DIVIDE) ? cnt_q + 1'b1 : '0;
    end
  end

  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    en      = 1'b0;
    case (state_q)
      S_IDLE:   if (start) state_d = S_UNPACK;
      S_UNPACK: begin
        load    = 1'b1;
        state_d = S_DIVIDE;
      end
      S_DIVIDE: begin
        en = 1'b1;
        if (cnt_q == CNT_W'(QW - 1)) state_d = S_NORM;
      end
      S_NORM:   state_d = S_ROUND;
      S_ROUND:  state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_comb begin
    sa = a_p0[DATA_W-1];
    sb = b_p0[DATA_W-1];
    ea = a_p0[DATA_W-2 -: EXP_W];
    eb = b_p0[DATA_W-2 -: EXP_W];
    fa = a_p0[MAN_W-1:0];
    fb = b_p0[MAN_W-1:0];
    sgn    = sa ^ sb;
    a_zero = (ea == '0);
    b_zero = (eb == '0);
    a_inf  = (&ea) && (fa == '0);
    b_inf  = (&eb) && (fb == '0);
    a_nan  = (&ea) && (fa != '0);
    b_nan  = (&eb) && (fb != '0);
    spec     = 1'b1;
    spec_res = '0;
    spec_flg = '0;
    if (a_nan || b_nan || (a_zero && b_zero) || (a_inf && b_inf)) begin
      spec_res         = QNAN;
      spec_flg.invalid = 1'b1;
    end else if (a_inf) begin
      spec_res = {sgn, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    end else if (b_zero) begin
      spec_res             = {sgn, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      spec_flg.div_by_zero = 1'b1;
    end else if (b_inf || a_zero) begin
      spec_res = {sgn, {(DATA_W-1){1'b0}}};
    end else begin
      spec = 1'b0;
    end
    e_unp = $signed({2'b00, ea}) - $signed({2'b00, eb}) + BIAS;
  end

  always_comb begin
    rnd        = round_ne(qn_p2[QW-1:2], qn_p2[1], qn_p2[0] | stk_p2);
    e_fin      = e_p2 + EW'(rnd[MAN_W+1]);
    packed_res = pack_sat(sgn_p1, e_fin, rnd[MAN_W-1:0]);
  end

  // Stage p0: operand capture on accept
  always_ff @(posedge clk) begin
    if (state_q == S_IDLE && start) begin
      a_p0 <= op_a;
      b_p0 <= op_b;
    end
    // Stage p1: sign, biased exponent and special-case result
    if (state_q == S_UNPACK) begin
      sgn_p1      <= sgn;
      e_p1        <= e_unp;
      spec_p1     <= spec;
      spec_res_p1 <= spec_res;
      spec_flg_p1 <= spec_flg;
    end
    // Stage p2: normalised quotient
    if (state_q == S_NORM) begin
      qn_p2  <= quo[QW-1] ? quo : {quo[QW-2:0], 1'b0};
      e_p2   <= quo[QW-1] ? e_p1 : e_p1 - 1'b1;
      stk_p2 <= stk;
    end
  end

  // Output stage: result and flags held until the next completion
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      done        <= 1'b0;
      res         <= '0;
      overflow    <= 1'b0;
      underflow   <= 1'b0;
      invalid     <= 1'b0;
      div_by_zero <= 1'b0;
    end else begin
      done <= (state_q == S_ROUND);
      if (state_q == S_ROUND) begin
        if (spec_p1) begin
          res         <= spec_res_p1;
          overflow    <= spec_flg_p1.overflow;
          underflow   <= spec_flg_p1.underflow;
          invalid     <= spec_flg_p1.invalid;
          div_by_zero <= spec_flg_p1.div_by_zero;
        end else begin
          res         <= packed_res[DATA_W-1:0];
          overflow    <= packed_res[DATA_W+1];
          underflow   <= packed_res[DATA_W];
          invalid     <= 1'b0;
          div_by_zero <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_fp_div_iter.sv
// Directed bench for fp_div_iter: single- and half-precision instances driven
// with hand-computed vectors, including specials, mid-operation start and reset.
module tb_fp_div_iter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [31:0] op_a = '0, op_b = '0;
  logic        busy, done, overflow, underflow, invalid, div_by_zero;
  logic [31:0] res;

  logic        h_start = 1'b0;
  logic [15:0] h_a = '0, h_b = '0;
  logic        h_busy, h_done, h_ovf, h_unf, h_inv, h_dbz;
  logic [15:0] h_res;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  fp_div_iter dut (
    .clk(clk), .rst(rst), .start(start), .op_a(op_a), .op_b(op_b),
    .busy(busy), .done(done), .res(res), .overflow(overflow),
    .underflow(underflow), .invalid(invalid), .div_by_zero(div_by_zero)
  );

  fp_div_iter #(.EXP_W(5), .MAN_W(10)) dut_h (
    .clk(clk), .rst(rst), .start(h_start), .op_a(h_a), .op_b(h_b),
    .busy(h_busy), .done(h_done), .res(h_res), .overflow(h_ovf),
    .underflow(h_unf), .invalid(h_inv), .div_by_zero(h_dbz)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Flags are compared as {overflow, underflow, invalid, div_by_zero}.
  task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp_res, input logic [3:0] exp_flg);
    int lat;
    op_a  = a;
    op_b  = b;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 0;
    while (!done && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    chk({tag, "_lat"}, lat, 29);
    chk({tag, "_res"}, res, exp_res);
    chk({tag, "_flg"}, {overflow, underflow, invalid, div_by_zero}, exp_flg);
  endtask

  initial begin
    int lat;
    int dones;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_res", res, 0);
    chk("rst_flg", {overflow, underflow, invalid, div_by_zero}, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    op_a = 32'h40C00000; op_b = 32'h40000000; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("accept_busy", busy, 1);
    lat = 0;
    while (!done && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("six_two_lat", lat, 29);
    chk("six_two_res", res, 32'h40400000);
    chk("six_two_flg", {overflow, underflow, invalid, div_by_zero}, 0);
    chk("done_busy_low", busy, 0);
    @(posedge clk); #1;
    chk("done_pulse", done, 0);
    chk("res_held", res, 32'h40400000);

    run_op("third",   32'h3F800000, 32'h40400000, 32'h3EAAAAAB, 4'b0000);
    run_op("neg",     32'hC0C00000, 32'h40000000, 32'hC0400000, 4'b0000);
    run_op("dbz",     32'h3F800000, 32'h00000000, 32'h7F800000, 4'b0001);
    run_op("zz",      32'h00000000, 32'h00000000, 32'h7FC00000, 4'b0010);
    run_op("nan",     32'h7F800001, 32'h3F800000, 32'h7FC00000, 4'b0010);
    run_op("infinf",  32'h7F800000, 32'hFF800000, 32'h7FC00000, 4'b0010);
    run_op("inf_fin", 32'h7F800000, 32'hC0000000, 32'hFF800000, 4'b0000);
    run_op("fin_inf", 32'h40000000, 32'h7F800000, 32'h00000000, 4'b0000);
    run_op("zero_n",  32'h80000000, 32'h40000000, 32'h80000000, 4'b0000);
    run_op("ovf",     32'h7F7FFFFF, 32'h3F000000, 32'h7F800000, 4'b1000);
    run_op("unf",     32'h00800000, 32'h40000000, 32'h00000000, 4'b0100);

    // Start pulsed mid-operation must be ignored.
    op_a = 32'h40C00000; op_b = 32'h40000000; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    op_a = 32'h3F800000; op_b = 32'h00000000; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 6;
    while (!done && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("ign_lat", lat, 29);
    chk("ign_res", res, 32'h40400000);
    chk("ign_flg", {overflow, underflow, invalid, div_by_zero}, 0);
    dones = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done) dones++;
    end
    chk("ign_single_done", dones, 0);

    // Reset during DIVIDE abandons the operation.
    op_a = 32'h3F800000; op_b = 32'h40400000; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_res", res, 0);
    chk("mid_rst_done", done, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    dones = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done) dones++;
    end
    chk("mid_rst_no_done", dones, 0);
    run_op("after_rst", 32'h40C00000, 32'h40000000, 32'h40400000, 4'b0000);

    // Half precision: 1.0 / 3.0
    h_a = 16'h3C00; h_b = 16'h4200; h_start = 1'b1;
    @(posedge clk); #1;
    h_start = 1'b0;
    lat = 0;
    while (!h_done && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("half_lat", lat, 16);
    chk("half_res", {16'h0, h_res}, 32'h00003555);
    chk("half_flg", {h_ovf, h_unf, h_inv, h_dbz}, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
